wbm_request: RTL

- Wishbone B4 pipelined initiator (master) that turns single command handshakes into single-beat bus cycles. Drives peripheral responders such as the charlieplexed display and future wbs_* blocks.
- Sits between a command source (UART debug bridge, CPU-less test sequencer) and the shared Wishbone bus.
- One transaction outstanding at a time. A bounded timeout reports a missing ack as an error response.

---
 rtl/wbm_request.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/wbm_request.sv
// wbm_request: Wishbone B4 pipelined initiator.
// Converts one command handshake into one single-beat bus cycle, with one
// transaction outstanding at a time. A missing ack is reported as an error
// response after a bounded number of cycles.
`timescale 1ns/1ps
module wbm_request #(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [3:0]        cmd_sel,
  input  logic [31:0]       cmd_dat,
  // response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_dat,
  output logic              rsp_err,
  // Wishbone bus
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_stall_i,
  input  logic              wb_ack_i
);

  // Counter only has to reach TIMEOUT_CYCLES-1, where it saturates.
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         dat_q, dat_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [31:0]         rsp_dat_q, rsp_dat_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_cycle_s;

  assign last_cycle_s = (cnt_q == CNT_LAST);

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          sel_d   = cmd_sel;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        // Budget runs from cyc assertion and saturates; an ack here is ignored.
        cnt_d = last_cycle_s ? cnt_q : cnt_q + CNT_W'(1);
        if (!wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = ST_WAIT;
        end else if (last_cycle_s) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = 32'h0000_0000;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_WAIT: begin
        cnt_d = last_cycle_s ? cnt_q : cnt_q + CNT_W'(1);
        if (wb_ack_i) begin
          rsp_dat_d   = we_q ? 32'h0000_0000 : wb_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          state_d     = ST_RESP;
        end else if (last_cycle_s) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = 32'h0000_0000;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= {ADDR_W{1'b0}};
      sel_q       <= 4'h0;
      dat_q       <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= 32'h0000_0000;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_sel_o  = sel_q;
  assign wb_dat_o  = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_dat   = rsp_dat_q;

endmodule
